// File: rtl/fp_add_sequencer.sv
// Issue sequencer for an external fixed-latency fp_add: registers operands, tracks each op
// through a valid/tag pipeline, and queues results in a credit-protected FIFO.
module fp_add_sequencer #(
  parameter int W       = 32,
  parameter int ADD_LAT = 2,
  parameter int TAG_W   = 5,
  parameter int FIFO_D  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  output logic             add_sub,
  output logic             add_en,
  input  logic [W-1:0]     add_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = $clog2(FIFO_D);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_D);

  logic [W-1:0]     add_a_q, add_b_q;
  logic             add_sub_q, add_en_q;
  logic [ADD_LAT:0] vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [ADD_LAT+1];
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [W-1:0]     mem_y   [FIFO_D];
  logic [TAG_W-1:0] mem_tag [FIFO_D];
  logic [CW:0]      occupancy;
  logic             accept, exit_vld, push, pop;

  // Every op in flight already owns a FIFO slot, so a push never meets a full FIFO.
  assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};
  assign in_ready  = ~flush & (occupancy < DEPTH);
  assign accept    = in_valid & in_ready;
  assign exit_vld  = vld_q[ADD_LAT];
  assign push      = exit_vld & ~flush;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    vld_d      = '0;
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (flush) begin
      inflight_d = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      vld_d[0] = accept;
      for (int i = 1; i <= ADD_LAT; i++) begin
        vld_d[i] = vld_q[i-1];
      end
      if (accept && !exit_vld) begin
        inflight_d = inflight_q + CW'(1);
      end else if (!accept && exit_vld) begin
        inflight_d = inflight_q - CW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_sub_q  <= 1'b0;
      add_en_q   <= 1'b0;
      vld_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i <= ADD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      add_en_q <= accept;
      if (accept) begin
        add_a_q   <= in_a;
        add_b_q   <= in_b;
        add_sub_q <= in_sub;
      end
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_q[0]   <= in_tag;
      for (int i = 1; i <= ADD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Storage needs no reset: the head is only looked at while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr_q]   <= add_y;
      mem_tag[wr_ptr_q] <= tag_q[ADD_LAT];
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_sub = add_sub_q;
  assign add_en  = add_en_q;
  assign out_y   = mem_y[rd_ptr_q];
  assign out_tag = mem_tag[rd_ptr_q];
  assign busy    = (inflight_q != '0) | (count_q != '0);

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: fixed-latency fp_add stand-in, queue-based result model
// checked every cycle, plus literal expectations from the directed vectors.
module tb_fp_add_sequencer;
  localparam int W       = 32;
  localparam int ADD_LAT = 2;
  localparam int TAG_W   = 5;
  localparam int FIFO_D  = 4;

  logic clk, reset_n, in_valid, in_ready, in_sub, flush;
  logic add_sub, add_en, out_valid, out_ready, busy;
  logic [W-1:0] in_a, in_b, add_a, add_b, add_y, out_y;
  logic [TAG_W-1:0] in_tag, out_tag;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  typedef struct {
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } ent_t;
  ent_t q[$];
  logic         m_en, m_sub, m_acc, m_ov;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] pipe [ADD_LAT];

  fp_add_sequencer #(.W(W), .ADD_LAT(ADD_LAT), .TAG_W(TAG_W), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_en(add_en), .add_y(add_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else begin
      e = {3'd0, x[30:23]} + 11'd896;
      d = {x[31], e, x[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    real r;
    r = s ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
    return r2f(r);
  endfunction

  // fp_add stand-in: result appears ADD_LAT cycles after the add_en cycle; junk otherwise.
  always @(posedge clk) begin
    pipe[0] <= add_en ? fp_op(add_a, add_b, add_sub) : 32'hDEADBEEF;
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_y = pipe[ADD_LAT-1];

  // Model: every accepted op is a queue entry until popped; visible from cycle accept+ADD_LAT+2.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_en  = 1'b0;
      m_a   = '0;
      m_b   = '0;
      m_sub = 1'b0;
    end else begin
      ent_t e;
      m_acc = in_valid && !flush && (q.size() < FIFO_D);
      m_ov  = (q.size() > 0) && (q[0].rdy <= cyc);
      if (flush) q.delete();
      else begin
        if (m_ov && out_ready) void'(q.pop_front());
        if (m_acc) begin
          e.y   = fp_op(in_a, in_b, in_sub);
          e.tag = in_tag;
          e.rdy = cyc + ADD_LAT + 2;
          q.push_back(e);
        end
      end
      m_en = m_acc;
      if (m_acc) begin
        m_a   = in_a;
        m_b   = in_b;
        m_sub = in_sub;
      end
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s timed out waiting on DUT (t=%0t)", nm, $time);
  endtask

  task automatic check_all();
    logic ov;
    if (!reset_n) begin
      chk("rst_add_a",     64'(add_a),     64'd0);
      chk("rst_add_b",     64'(add_b),     64'd0);
      chk("rst_add_sub",   64'(add_sub),   64'd0);
      chk("rst_add_en",    64'(add_en),    64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'(!flush));
    end else begin
      ov = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("in_ready",  64'(in_ready),  64'(!flush && (q.size() < FIFO_D)));
      chk("add_en",    64'(add_en),    64'(m_en));
      chk("add_a",     64'(add_a),     64'(m_a));
      chk("add_b",     64'(add_b),     64'(m_b));
      chk("add_sub",   64'(add_sub),   64'(m_sub));
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("busy",      64'(busy),      64'(q.size() != 0));
      if (ov) begin
        chk("out_y",   64'(out_y),   64'(q[0].y));
        chk("out_tag", 64'(out_tag), 64'(q[0].tag));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [TAG_W-1:0] t);
    logic r;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = s;
    in_tag = t;
    for (int k = 0; k < 30; k++) begin
      r = in_ready;
      tick();
      if (r) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    timeout("send");
  endtask

  task automatic wait_ov(input string nm);
    for (int k = 0; k < 20; k++) begin
      if (out_valid) return;
      tick();
    end
    timeout(nm);
  endtask

  initial begin
    int c0;
    int lag;
    logic r;
    reset_n = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    ticks(2);
    reset_n = 1'b1;
    out_ready = 1'b1;

    // 1.0 + 2.0 accepted in the very first cycle after reset release
    c0 = cyc;
    chk("s1_ready", 64'(in_ready), 64'd1);
    send(32'h3F800000, 32'h40000000, 1'b0, 5'd3);
    wait_ov("s1_wait");
    chk("s1_latency", 64'(cyc - c0), 64'd4);
    chk("s1_y",   64'(out_y),   64'h40400000);
    chk("s1_tag", 64'(out_tag), 64'd3);
    tick();

    // back-to-back 3.0-1.0 then 5.0+0.5
    send(32'h40400000, 32'h3F800000, 1'b1, 5'd1);
    send(32'h40A00000, 32'h3F000000, 1'b0, 5'd2);
    wait_ov("s2_wait");
    chk("s2_y0",   64'(out_y),   64'h40000000);
    chk("s2_tag0", 64'(out_tag), 64'd1);
    tick();
    chk("s2_v1",   64'(out_valid), 64'd1);
    chk("s2_y1",   64'(out_y),     64'h40B00000);
    chk("s2_tag1", 64'(out_tag),   64'd2);
    ticks(2);

    // credit limit: 4 accepted with consumer stalled, 5th waits for a pop
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 5'd4);
    send(32'h40000000, 32'h40000000, 1'b0, 5'd5);
    send(32'h3F800000, 32'h40000000, 1'b0, 5'd6);
    send(32'h40A00000, 32'h3F800000, 1'b1, 5'd7);
    in_valid = 1'b1; in_a = 32'h3F000000; in_b = 32'h3F000000; in_sub = 1'b0; in_tag = 5'd8;
    ticks(5);
    chk("s3_full_ready", 64'(in_ready),  64'd0);
    chk("s3_head_v",     64'(out_valid), 64'd1);
    chk("s3_head_y",     64'(out_y),     64'h40000000);
    chk("s3_head_tag",   64'(out_tag),   64'd4);
    out_ready = 1'b1;
    lag = -1;
    for (int k = 0; k < 10; k++) begin
      r = in_ready;
      tick();
      if (r) begin
        lag = k;
        break;
      end
    end
    in_valid = 1'b0;
    chk("s3_credit_lag", 64'(lag), 64'd1);
    ticks(10);

    // full FIFO drained while new ops are accepted alongside pops
    out_ready = 1'b0;
    send(32'h40400000, 32'h40800000, 1'b0, 5'd10);
    send(32'h40800000, 32'h40800000, 1'b0, 5'd11);
    send(32'h40E00000, 32'h3F800000, 1'b1, 5'd12);
    send(32'h41000000, 32'h40000000, 1'b0, 5'd13);
    ticks(6);
    out_ready = 1'b1;
    send(32'h3F800000, 32'h3F000000, 1'b0, 5'd14);
    send(32'h40C00000, 32'h40000000, 1'b1, 5'd15);
    send(32'h3F000000, 32'h40400000, 1'b0, 5'd16);
    ticks(10);
    chk("s4_idle", 64'(busy), 64'd0);

    // flush with one queued and two in flight; a request offered during flush is refused
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 5'd9);
    ticks(4);
    send(32'h40000000, 32'h3F800000, 1'b0, 5'd18);
    send(32'h40800000, 32'h3F800000, 1'b1, 5'd19);
    flush = 1'b1;
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000; in_sub = 1'b0; in_tag = 5'd20;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("s5_ov",   64'(out_valid), 64'd0);
    chk("s5_busy", 64'(busy),      64'd0);
    out_ready = 1'b1;
    ticks(8);
    chk("s5_no_stale", 64'(out_valid), 64'd0);

    // async reset with three ops in flight
    send(32'h3F800000, 32'h3F800000, 1'b0, 5'd21);
    send(32'h40000000, 32'h3F800000, 1'b0, 5'd22);
    send(32'h40400000, 32'h3F800000, 1'b0, 5'd23);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_add_en", 64'(add_en),    64'd0);
    chk("s6_add_a",  64'(add_a),     64'd0);
    chk("s6_ov",     64'(out_valid), 64'd0);
    chk("s6_busy",   64'(busy),      64'd0);
    chk("s6_ready",  64'(in_ready),  64'd1);
    ticks(2);
    reset_n = 1'b1;
    send(32'h40000000, 32'h40800000, 1'b0, 5'd17);
    wait_ov("s6_wait");
    chk("s6_y",   64'(out_y),   64'h40C00000);
    chk("s6_tag", 64'(out_tag), 64'd17);
    tick();
    chk("s6_alone", 64'(out_valid), 64'd0);
    ticks(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
